// File: rtl/pyramic_audio_clkgen.sv
// Lock qualification, ADC reset sequencing and SCLK/LRCK generation for the Pyramic capture path.
// Define PYRAMIC_CLKGEN_STICKY_ERR_EN to latch lock loss in RUN into a halt state until rst.
module pyramic_audio_clkgen #(
    parameter int SCLK_HALF_DIV      = 2,
    parameter int BITS_PER_FRAME     = 64,
    parameter int LOCK_STABLE_CYCLES = 4096,
    parameter int ADC_RST_CYCLES     = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       enable,
    output logic       ready,
    output logic       adc_rst_n,
    output logic       sclk,
    output logic       lrck,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       frame_start,
    output logic [5:0] bit_index,
    output logic       lock_lost
);

    localparam int DIV_W   = (SCLK_HALF_DIV > 1) ? $clog2(2 * SCLK_HALF_DIV) : 1;
    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > ADC_RST_CYCLES) ? LOCK_STABLE_CYCLES : ADC_RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(2 * SCLK_HALF_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF    = DIV_W'(SCLK_HALF_DIV);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ADC_LAST    = CNT_W'(ADC_RST_CYCLES - 1);
    localparam logic [5:0]       BIT_LAST    = 6'(BITS_PER_FRAME - 1);
    localparam logic [5:0]       BIT_HALF    = 6'(BITS_PER_FRAME / 2);

    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] STABILIZE = 3'd1;
    localparam logic [2:0] ADC_RESET = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
`ifdef PYRAMIC_CLKGEN_STICKY_ERR_EN
    localparam logic [2:0] HALT      = 3'd4;
`endif

    logic             lk_meta;
    logic             lk;
    logic [2:0]       state;
    logic [2:0]       nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic             lost_evt;
    logic             active;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_inc;
    logic             fall_evt;
    logic [5:0]       bit_inc;
    logic             gen_on;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        lost_evt  = 1'b0;
        case (state)
            WAIT_LOCK: begin
                nxt_cnt = '0;
                if (lk) nxt_state = STABILIZE;
            end
            STABILIZE: begin
                if (!lk) begin
                    nxt_state = WAIT_LOCK;
                    nxt_cnt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    nxt_state = ADC_RESET;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            ADC_RESET: begin
                if (!lk) begin
                    nxt_state = WAIT_LOCK;
                    nxt_cnt   = '0;
                end else if (cnt == ADC_LAST) begin
                    nxt_state = RUN;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            RUN: begin
                nxt_cnt = '0;
                if (!lk) begin
                    lost_evt = 1'b1;
`ifdef PYRAMIC_CLKGEN_STICKY_ERR_EN
                    nxt_state = HALT;
`else
                    nxt_state = WAIT_LOCK;
`endif
                end
            end
`ifdef PYRAMIC_CLKGEN_STICKY_ERR_EN
            HALT: begin
                nxt_cnt = '0;
            end
`endif
            default: begin
                nxt_state = WAIT_LOCK;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so that they change on the same edge as the state.
    always_comb begin
        gen_on   = (nxt_state == RUN) && enable;
        div_inc  = (div == DIV_LAST) ? '0 : div + 1'b1;
        fall_evt = (div_inc == '0);
        bit_inc  = bit_index;
        if (fall_evt) bit_inc = (bit_index == BIT_LAST) ? '0 : bit_index + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lk_meta     <= 1'b0;
            lk          <= 1'b0;
            state       <= WAIT_LOCK;
            cnt         <= '0;
            ready       <= 1'b0;
            adc_rst_n   <= 1'b0;
            lock_lost   <= 1'b0;
            active      <= 1'b0;
            div         <= '0;
            bit_index   <= '0;
            sclk        <= 1'b0;
            lrck        <= 1'b0;
            sclk_rise   <= 1'b0;
            sclk_fall   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            lk_meta   <= pll_locked;
            lk        <= lk_meta;
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            ready     <= (nxt_state == RUN);
            adc_rst_n <= (nxt_state == RUN);
`ifdef PYRAMIC_CLKGEN_STICKY_ERR_EN
            lock_lost <= lock_lost | lost_evt;
`else
            lock_lost <= lost_evt;
`endif
            if (gen_on && active) begin
                div         <= div_inc;
                bit_index   <= bit_inc;
                sclk        <= (div_inc >= DIV_HALF);
                lrck        <= (bit_inc >= BIT_HALF);
                sclk_rise   <= (div_inc == DIV_HALF);
                sclk_fall   <= fall_evt;
                frame_start <= fall_evt && (bit_inc == '0);
            end else if (gen_on) begin
                active      <= 1'b1;
                div         <= '0;
                bit_index   <= '0;
                sclk        <= 1'b0;
                lrck        <= 1'b0;
                sclk_rise   <= 1'b0;
                sclk_fall   <= 1'b0;
                frame_start <= 1'b1;
            end else begin
                active      <= 1'b0;
                div         <= '0;
                bit_index   <= '0;
                sclk        <= 1'b0;
                lrck        <= 1'b0;
                sclk_rise   <= 1'b0;
                sclk_fall   <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pyramic_audio_clkgen.md
# pyramic_audio_clkgen

- Sits directly downstream of the array PLL: runs on its 12.288 MHz output and consumes its `locked` flag.
- Qualifies lock, sequences the ADC reset release, then generates the serial-audio bit clock (SCLK), frame clock (LRCK) and clk-domain strobes for the capture path.
- Defaults give SCLK = 3.072 MHz (64·fs) and LRCK = 48 kHz.

## Interface
Parameters:
- `SCLK_HALF_DIV`, 2: clk cycles per SCLK half-period; ≥1.
- `BITS_PER_FRAME`, 64: SCLK periods per LRCK frame; even, power of two, ≤64.
- `LOCK_STABLE_CYCLES`, 4096: cycles synchronized lock must stay high before the ADC reset sequence; ≥1.
- `ADC_RST_CYCLES`, 1024: cycles `adc_rst_n` is held low after lock qualification; ≥1.

Ports:
- `clk` in 1: PLL output clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL lock, asynchronous; 2-flop synchronized internally.
- `enable` in 1: run SCLK/LRCK when high (RUN state only).
- `ready` out 1: high in RUN.
- `adc_rst_n` out 1: ADC reset, active low.
- `sclk` out 1: serial bit clock.
- `lrck` out 1: frame clock; 0 = left half, 1 = right half.
- `sclk_rise` out 1: 1-cycle pulse, first cycle of each `sclk` high phase.
- `sclk_fall` out 1: 1-cycle pulse, first cycle of each `sclk` low phase after a high phase.
- `frame_start` out 1: 1-cycle pulse at start of each frame.
- `bit_index` out 6: SCLK period index within frame, 0..BITS_PER_FRAME-1.
- `lock_lost` out 1: lock dropped while in RUN.

## Operation
- All outputs are registered.
- Reset values: state WAIT_LOCK; `ready`=0, `adc_rst_n`=0, `sclk`=0, `lrck`=0, all pulses 0, `bit_index`=0, `lock_lost`=0; counters 0.

States:
- WAIT_LOCK: exits to STABILIZE when synchronized lock `lk`=1.
- STABILIZE: counts LOCK_STABLE_CYCLES cycles, then goes to ADC_RESET. If `lk`=0, goes to WAIT_LOCK and the counter clears.
- ADC_RESET: `adc_rst_n`=0 for ADC_RST_CYCLES cycles, then goes to RUN. If `lk`=0, goes to WAIT_LOCK.
- RUN: `ready`=1, `adc_rst_n`=1. Lock loss handling depends on Configuration.

Clock generation in RUN with `enable`=1:
- Divider `div` counts 0..2·SCLK_HALF_DIV-1 and wraps.
- `sclk`=1 exactly when `div`≥SCLK_HALF_DIV.
- `sclk_rise` coincides with the 0→1 transition of `sclk`.
- `sclk_fall` coincides with each 1→0 transition of `sclk`.
- `bit_index` increments modulo BITS_PER_FRAME in the `sclk_fall` cycle.
- `lrck` = (`bit_index` ≥ BITS_PER_FRAME/2), so it changes only on SCLK falling edges.
- `frame_start`=1 in the first enabled RUN cycle and in every `sclk_fall` cycle where `bit_index` wraps to 0.

`enable`=0 in RUN:
- `div`, `bit_index`, `sclk`, `lrck` and pulses are forced to 0 on the next cycle.
- Re-enabling starts a fresh frame with `frame_start`.

Leaving RUN for any reason (including `rst`):
- Clock outputs return to reset values on the next edge.
- No partial-frame completion.

## Timing
- `pll_locked` sampled high at edge k, held high:
  - STABILIZE from edge k+2;
  - ADC_RESET from edge k+2+LOCK_STABLE_CYCLES;
  - `ready`=1 and `adc_rst_n`=1 visible after edge k+2+LOCK_STABLE_CYCLES+ADC_RST_CYCLES.
- Lock-drop detection latency: 2 cycles synchronizer + 1 cycle state update.
- SCLK period is 2·SCLK_HALF_DIV clk cycles, 50% duty. Frame is 2·SCLK_HALF_DIV·BITS_PER_FRAME cycles (256 at defaults).
- Within one frame, `frame_start` and `sclk_fall` coincide at the wrap, except the first frame after enable, where `sclk`=0 and no fall pulse is issued.
- `rst` asserted together with any event has priority.

## Configuration
- `PYRAMIC_CLKGEN_STICKY_ERR_EN` defined:
  - lock loss in RUN sets `lock_lost`=1 and enters a halt state: all outputs at reset values except `lock_lost`;
  - the halt state exits only via `rst`, which also clears `lock_lost`.
- Undefined:
  - lock loss in RUN returns to WAIT_LOCK and the sequence re-runs automatically on relock;
  - `lock_lost` pulses high for exactly one cycle at the transition.

## Test plan
Parameters LOCK_STABLE_CYCLES=8, ADC_RST_CYCLES=4 unless noted.
- Lock-up: `pll_locked` rises at edge 10 → `adc_rst_n` and `ready` rise after edge 24; both low before.
- Glitch: `lk` drops for 1 cycle mid-STABILIZE → return to WAIT_LOCK; full 8+4 cycles re-counted after relock.
- Clocking, defaults: `sclk` period 4 cycles, 64 `sclk_fall` per frame. `lrck` rises at `bit_index`=32 and falls at wrap. `frame_start` spacing exactly 256 cycles.
- Enable toggle: `enable` low for 10 cycles mid-frame → outputs 0 on the next cycle; on re-enable, `frame_start` in the first enabled cycle and `bit_index`=0.
- Lock loss in RUN:
  - with macro: `lock_lost` sticky high and outputs idle until `rst`;
  - without: 1-cycle `lock_lost` pulse, then automatic re-sequence to `ready`.
- Reset mid-frame: `rst` asserted at `bit_index`=17 → all outputs at reset values after that edge.
